// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler for a 5-stage core (IF/ID/EX/MEM/WB).
// Tracks a countdown per architectural register until its pending write
// reaches the regfile, stalls ID on RAW hazards, and drives every stage
// enable/flush, including jump squash, halt freeze and memory-wait freeze.
module hazard_sched #(
  parameter int NREG     = 8,
  parameter int WB_LAT   = 3,
  parameter int READY_AT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_id,
  input  logic                    rs1_used,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic                    rs2_used,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic                    rd_write,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic                    jump,
  input  logic                    is_halt_id,
  input  logic                    mem_stall,
  output logic                    en_pc,
  output logic                    en_ifid,
  output logic                    en_idex,
  output logic                    en_exmem,
  output logic                    en_memwb,
  output logic                    flush_ifid,
  output logic                    flush_idex,
  output logic                    flush_exmem,
  output logic                    flush_memwb,
  output logic                    stall_id,
  output logic                    halted,
  output logic [NREG-1:0]         busy_mask
);

  localparam int IW = $clog2(NREG);
  localparam int CW = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] LAT_C   = CW'(WB_LAT);
  localparam logic [CW-1:0] READY_C = CW'(READY_AT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic {RUN, HALT} mode_t;

  mode_t         mode, mode_next;
  logic [CW-1:0] cnt [NREG];
  logic          issue;

  assign halted = (mode == HALT);

  // RAW hazard: a used source whose producer has not yet reached the regfile.
  // The check sees the counters before this cycle's own write, so an
  // instruction whose rd equals one of its sources never stalls on itself.
  assign stall_id = ~reset & valid_id & ~halted &
                    ((rs1_used & (cnt[rs1] > READY_C)) |
                     (rs2_used & (cnt[rs2] > READY_C)));

  assign issue = valid_id & ~stall_id & ~mem_stall & ~halted & ~reset;

  // Halt mode register: entered when HLT issues, left only by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the same pre-edge values regardless of block order.
    if (reset) mode <= RUN;
    else       mode <= mode_next;
  end

  // Next halt mode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    mode_next = mode;
    if (issue && is_halt_id) mode_next = HALT;
  end

  // Pending-write counters: reload on issue of a writer, otherwise count
  // down to zero; frozen while memory stalls the pipe.
  always_ff @(posedge clk) begin
    // NOTE: the counter array is small flop storage, not RAM, so it is reset
    // explicitly; a stale count after reset would stall the first consumer.
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else if (!mem_stall) begin
      for (int i = 0; i < NREG; i++) begin
        if (issue && rd_write && (rd == IW'(i))) cnt[i] <= LAT_C;
        else if (cnt[i] != '0)                   cnt[i] <= cnt[i] - ONE_C;
      end
    end
  end

  // Busy mask: any register still awaiting writeback.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NREG; i++) busy_mask[i] = (cnt[i] != '0);
  end

  // Stage enables and flushes, highest-priority condition first.
  always_comb begin
    en_pc       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    if (reset) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else if (mem_stall) begin
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
    end else if (halted || stall_id) begin
      // Front end holds; a bubble enters EX while the back end drains.
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      flush_idex = 1'b1;
    end else if (valid_id && jump) begin
      flush_ifid = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed vector table, a hand-written memory-stall
// sequence, and randomized stimulus against a tick-based reference model.
module tb_hazard_sched;

  localparam int WB_LAT   = 3;
  localparam int READY_AT = 0;

  localparam int EN_ALL  = 'b11111;
  localparam int EN_HOLD = 'b00111;
  localparam int EN_NONE = 'b00000;
  localparam int FL_ALL  = 'b1111;
  localparam int FL_BUB  = 'b0100;
  localparam int FL_J    = 'b1000;
  localparam int FL_0    = 'b0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_id = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0, rd_write = 1'b0;
  logic [2:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       jump = 1'b0, is_halt_id = 1'b0, mem_stall = 1'b0;
  logic       en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic       stall_id, halted;
  logic [7:0] busy_mask;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_sched #(.NREG(8), .WB_LAT(WB_LAT), .READY_AT(READY_AT)) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id),
    .rs1_used(rs1_used), .rs1(rs1), .rs2_used(rs2_used), .rs2(rs2),
    .rd_write(rd_write), .rd(rd), .jump(jump), .is_halt_id(is_halt_id),
    .mem_stall(mem_stall),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .stall_id(stall_id), .halted(halted), .busy_mask(busy_mask)
  );

  typedef struct {
    logic       rst, vld, r1u;
    logic [2:0] r1;
    logic       r2u;
    logic [2:0] r2;
    logic       rdw;
    logic [2:0] rd;
    logic       jmp, hlt, ms;
    logic [4:0] en;   // {pc, ifid, idex, exmem, memwb}
    logic [3:0] fl;   // {ifid, idex, exmem, memwb}
    logic       st, h;
    logic [7:0] busy;
    logic       skip; // compare only enables/flushes/stall
  } vec_t;

  function automatic vec_t mk(input int rst, vld, r1u, r1, r2u, r2, rdw, rdx,
                              jmp, hlt, ms, en, fl, st, h, busy, skip);
    vec_t v;
    v.rst = rst[0]; v.vld = vld[0]; v.r1u = r1u[0]; v.r1 = 3'(r1);
    v.r2u = r2u[0]; v.r2 = 3'(r2); v.rdw = rdw[0]; v.rd = 3'(rdx);
    v.jmp = jmp[0]; v.hlt = hlt[0]; v.ms = ms[0];
    v.en = 5'(en); v.fl = 4'(fl); v.st = st[0]; v.h = h[0];
    v.busy = 8'(busy); v.skip = skip[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (en5 fl4 st h busy8)", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and compare the
  // combinational outputs before the next rising edge.
  task automatic apply(input vec_t v, input string name);
    logic [18:0] got, exp;
    @(negedge clk);
    reset = v.rst; valid_id = v.vld; rs1_used = v.r1u; rs1 = v.r1;
    rs2_used = v.r2u; rs2 = v.r2; rd_write = v.rdw; rd = v.rd;
    jump = v.jmp; is_halt_id = v.hlt; mem_stall = v.ms;
    #1;
    got = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb,
           stall_id, halted, busy_mask};
    exp = {v.en, v.fl, v.st, v.h, v.busy};
    if (v.skip) check(name, 32'(got[18:9]), 32'(exp[18:9]));
    else        check(name, 32'(got), 32'(exp));
  endtask

  // Reference model: a register is unreadable until the count of
  // non-frozen cycles reaches the tick at which its write lands.
  int tick = 0;
  int ready_tick [8];
  bit halted_m = 1'b0;

  function automatic int rem(input int r);
    return (ready_tick[r] > tick) ? ready_tick[r] - tick : 0;
  endfunction

  vec_t tbl [$];

  initial begin
    vec_t v;
    foreach (ready_tick[i]) ready_tick[i] = 0;
    @(posedge clk);

    // rst vld r1u r1 r2u r2 rdw rd jmp hlt ms | en fl st h busy skip
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, EN_ALL, FL_ALL,0,0,'h00,0)); // reset
    tbl.push_back(mk(0,1,0,0,0,0,1,1,0,0,0, EN_ALL, FL_0,  0,0,'h00,0)); // ADD r1
    tbl.push_back(mk(0,1,1,1,0,0,1,2,0,0,0, EN_HOLD,FL_BUB,1,0,'h02,0)); // RAW r1 (3)
    tbl.push_back(mk(0,1,1,1,0,0,1,2,0,0,0, EN_HOLD,FL_BUB,1,0,'h02,0)); // (2)
    tbl.push_back(mk(0,1,1,1,0,0,1,2,1,0,0, EN_HOLD,FL_BUB,1,0,'h02,0)); // (1) stall beats jump
    tbl.push_back(mk(0,1,1,1,0,0,1,2,0,0,0, EN_ALL, FL_0,  0,0,'h00,0)); // issues 4th
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,0, EN_ALL, FL_J,  0,0,'h04,0)); // jump
    tbl.push_back(mk(0,1,0,0,1,2,0,0,0,0,1, EN_NONE,FL_0,  1,0,'h04,0)); // mem_stall
    tbl.push_back(mk(0,1,0,0,1,2,0,0,0,0,1, EN_NONE,FL_0,  1,0,'h04,0)); // cnt held
    tbl.push_back(mk(0,1,0,0,1,2,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h04,0)); // cnt 2
    tbl.push_back(mk(0,1,0,0,1,2,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h04,0)); // cnt 1
    tbl.push_back(mk(0,1,0,0,1,2,0,0,0,0,0, EN_ALL, FL_0,  0,0,'h00,0)); // issue
    tbl.push_back(mk(0,1,0,0,0,0,1,5,0,1,0, EN_ALL, FL_0,  0,0,'h00,0)); // HLT writing r5
    tbl.push_back(mk(0,1,1,5,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,0,1,'h20,0)); // halted, no stall
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,0,1,'h20,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,0, EN_HOLD,FL_BUB,0,1,'h20,0)); // jump ignored
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,0,1,'h00,0)); // drained
    tbl.push_back(mk(1,1,1,5,0,0,0,0,0,0,0, EN_ALL, FL_ALL,0,0,'h00,1)); // reset mid-halt
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, EN_ALL, FL_0,  0,0,'h00,0)); // clean
    tbl.push_back(mk(0,1,0,0,0,0,1,7,0,0,0, EN_ALL, FL_0,  0,0,'h00,0)); // write r7
    tbl.push_back(mk(0,1,1,7,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h80,0)); // stall
    tbl.push_back(mk(1,1,1,7,0,0,0,0,0,0,0, EN_ALL, FL_ALL,0,0,'h80,1)); // reset mid-stall
    tbl.push_back(mk(0,1,1,7,0,0,0,0,0,0,0, EN_ALL, FL_0,  0,0,'h00,0)); // clean issue
    tbl.push_back(mk(0,1,0,0,0,0,1,2,0,0,0, EN_ALL, FL_0,  0,0,'h00,0)); // write r2
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0, EN_ALL, FL_0,  0,0,'h04,0));
    tbl.push_back(mk(0,1,0,0,0,0,1,2,0,0,0, EN_ALL, FL_0,  0,0,'h04,0)); // rewrite r2
    tbl.push_back(mk(0,1,1,2,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h04,0)); // reloaded 3
    tbl.push_back(mk(0,1,1,2,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h04,0));
    tbl.push_back(mk(0,1,1,2,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h04,0));
    tbl.push_back(mk(0,1,1,2,0,0,0,0,0,0,0, EN_ALL, FL_0,  0,0,'h00,0));
    tbl.push_back(mk(0,1,1,4,0,0,1,4,0,0,0, EN_ALL, FL_0,  0,0,'h00,0)); // rd==rs1, no self-stall
    tbl.push_back(mk(0,1,1,4,1,4,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h10,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, EN_ALL, FL_ALL,0,0,'h10,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Memory stall held five cycles while r3 has two cycles left.
    apply(mk(0,1,0,0,0,0,1,3,0,0,0, EN_ALL, FL_0,  0,0,'h00,0), "ms_write_r3");
    apply(mk(0,0,0,0,0,0,0,0,0,0,0, EN_ALL, FL_0,  0,0,'h08,0), "ms_gap");
    for (int i = 0; i < 5; i++)
      apply(mk(0,1,1,3,0,0,0,0,0,0,1, EN_NONE,FL_0,1,0,'h08,0), $sformatf("ms_hold%0d", i));
    apply(mk(0,1,1,3,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h08,0), "ms_rel0");
    apply(mk(0,1,1,3,0,0,0,0,0,0,0, EN_HOLD,FL_BUB,1,0,'h08,0), "ms_rel1");
    apply(mk(0,1,1,3,0,0,0,0,0,0,0, EN_ALL, FL_0,  0,0,'h00,0), "ms_issue");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      bit issue_m;
      v.rst = (n == 0) || ($urandom_range(0, 99) == 0);
      v.vld = ($urandom_range(0, 3) != 0);
      v.r1u = 1'($urandom); v.r1 = 3'($urandom);
      v.r2u = 1'($urandom); v.r2 = 3'($urandom);
      v.rdw = 1'($urandom); v.rd = 3'($urandom);
      v.jmp = ($urandom_range(0, 5) == 0);
      v.hlt = ($urandom_range(0, 39) == 0);
      v.ms  = ($urandom_range(0, 7) == 0);
      v.skip = 1'b0;
      v.h = halted_m;
      v.busy = '0;
      for (int r = 0; r < 8; r++) v.busy[r] = (rem(r) != 0);
      v.st = !v.rst && v.vld && !halted_m &&
             ((v.r1u && rem(v.r1) > READY_AT) || (v.r2u && rem(v.r2) > READY_AT));
      if (v.rst)                   begin v.en = 5'(EN_ALL);  v.fl = 4'(FL_ALL); end
      else if (v.ms)               begin v.en = 5'(EN_NONE); v.fl = 4'(FL_0);   end
      else if (halted_m || v.st)   begin v.en = 5'(EN_HOLD); v.fl = 4'(FL_BUB); end
      else if (v.vld && v.jmp)     begin v.en = 5'(EN_ALL);  v.fl = 4'(FL_J);   end
      else                         begin v.en = 5'(EN_ALL);  v.fl = 4'(FL_0);   end
      apply(v, $sformatf("rand%0d", n));

      issue_m = v.vld && !v.st && !v.ms && !halted_m && !v.rst;
      if (v.rst) begin
        foreach (ready_tick[r]) ready_tick[r] = tick;
        halted_m = 1'b0;
      end else if (!v.ms) begin
        if (issue_m && v.rdw) ready_tick[v.rd] = tick + 1 + WB_LAT;
        if (issue_m && v.hlt) halted_m = 1'b1;
        tick++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
